// File: rtl/qdec_pkg.sv
// qdec_pkg: shared states, Gray phases and step classification for the quadrature decoder
package qdec_pkg;
  typedef enum logic {INIT, TRACK} state_t;
  typedef enum logic [1:0] {NONE, FWD, REV, ILLEGAL} step_t;
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;
  function automatic logic [1:0] fwd_of(input logic [1:0] p);
    return p == PH0 ? PH1 : p == PH1 ? PH2 : p == PH2 ? PH3 : PH0;
  endfunction
  function automatic step_t classify(input logic [1:0] p, input logic [1:0] n);
    return p == n ? NONE : n == fwd_of(p) ? FWD : p == fwd_of(n) ? REV : ILLEGAL;
  endfunction
endpackage

// File: rtl/qdec_filter.sv
// qdec_filter: 2-flop synchroniser plus FILTER_LEN-cycle glitch filter for one encoder bit
module qdec_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt,
  output logic o_busy
);
  localparam logic [3:0] LEN = 4'(FILTER_LEN);
  logic r_s1, r_s2, r_filt;
  logic [3:0] r_cnt;
  // synchronise, then accept a new level only after it has held LEN cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_filt <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) r_cnt <= 4'd0;
      else if (r_cnt + 4'd1 == LEN) begin
        r_filt <= r_s2;
        r_cnt <= 4'd0;
      end else r_cnt <= r_cnt + 4'd1;
    end
  end
  assign o_filt = r_filt;
  // busy covers levels still in the synchroniser so settling waits for them too
  assign o_busy = (r_cnt != 4'd0) | (r_s1 != r_filt) | (r_s2 != r_filt);
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B/index to count/direction/load pulses; QDEC_X1_DECODE_EN selects X1 decoding
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  input  logic idx_in,
  input  logic err_clr,
  output logic enable,
  output logic updown,
  output logic load,
  output logic error
);
  localparam logic [3:0] LEN = 4'(FILTER_LEN);
  logic w_a, w_b, w_idx, w_fwd, w_rev, w_quiet;
  logic [2:0] w_busy;
  logic [1:0] w_ab;
  step_t w_step;
  state_t r_state;
  logic [1:0] r_prev;
  logic r_idx_prev, r_en, r_ud, r_ld, r_err;
  logic [3:0] r_settle;
  qdec_filter #(.FILTER_LEN(FILTER_LEN)) u_fa (.clock(clock), .reset(reset), .i_raw(a_in), .o_filt(w_a), .o_busy(w_busy[0]));
  qdec_filter #(.FILTER_LEN(FILTER_LEN)) u_fb (.clock(clock), .reset(reset), .i_raw(b_in), .o_filt(w_b), .o_busy(w_busy[1]));
  qdec_filter #(.FILTER_LEN(FILTER_LEN)) u_fi (.clock(clock), .reset(reset), .i_raw(idx_in), .o_filt(w_idx), .o_busy(w_busy[2]));
  assign w_ab = {w_a, w_b};
  assign w_quiet = ~|w_busy;
  assign w_step = classify(r_prev, w_ab);
`ifdef QDEC_X1_DECODE_EN
  assign w_fwd = w_step == FWD && r_prev == PH0;
  assign w_rev = w_step == REV && r_prev == PH1;
`else
  assign w_fwd = w_step == FWD;
  assign w_rev = w_step == REV;
`endif
  // settle in INIT adopting the resting phase, then decode steps and index in TRACK
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT;
      r_prev <= 2'b00;
      r_idx_prev <= 1'b0;
      r_settle <= 4'd0;
      r_en <= 1'b0;
      r_ud <= 1'b0;
      r_ld <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_prev <= w_ab;
      r_idx_prev <= w_idx;
      r_err <= (r_state == TRACK && w_step == ILLEGAL) | (r_err & ~err_clr);
      if (r_state == INIT) begin
        r_en <= 1'b0;
        r_ld <= 1'b0;
        r_settle <= w_quiet ? r_settle + 4'd1 : 4'd0;
        if (w_quiet && r_settle + 4'd1 == LEN) r_state <= TRACK;
      end else begin
        r_en <= w_fwd | w_rev;
        r_ud <= w_fwd ? 1'b0 : w_rev ? 1'b1 : r_ud;
        r_ld <= w_idx & ~r_idx_prev;
      end
    end
  end
  assign enable = r_en;
  assign updown = r_ud;
  assign load = r_ld;
  assign error = r_err;
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed self-checking bench for quad_step_decoder (X4 build, FILTER_LEN=3)
module tb_quad_step_decoder;
  logic clock = 1'b0, reset = 1'b1, a_in = 1'b0, b_in = 1'b0, idx_in = 1'b0, err_clr = 1'b0;
  logic enable, updown, load, error;
  int n_chk = 0, n_err = 0;
  int n_en, n_up, n_wide, n_ld, n_both;
  logic prev_en;
  logic [1:0] fwd_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int first_e, first_ud, second_e, second_ud;

  quad_step_decoder #(.FILTER_LEN(3)) dut (
    .clock(clock), .reset(reset), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .err_clr(err_clr), .enable(enable), .updown(updown), .load(load), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    a_in = v[1];
    b_in = v[0];
  endtask

  task automatic clr();
    n_en = 0; n_up = 0; n_wide = 0; n_ld = 0; n_both = 0; prev_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (enable) begin
        n_en++;
        if (updown) n_up++;
        if (prev_en) n_wide++;
      end
      if (load) n_ld++;
      if (load && enable) n_both++;
      prev_en = enable;
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_enable", enable, 0);
    chk("rst_updown", updown, 0);
    chk("rst_load", load, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    run(15);

    clr();
    for (int i = 1; i <= 8; i++) begin
      set_ab(fwd_seq[i % 4]);
      run(10);
    end
    chk("fwd_pulses", n_en, 8);
    chk("fwd_updown", n_up, 0);
    chk("fwd_width", n_wide, 0);
    chk("fwd_error", error, 0);

    clr();
    for (int i = 3; i >= 0; i--) begin
      set_ab(fwd_seq[i]);
      run(10);
    end
    chk("rev_pulses", n_en, 4);
    chk("rev_updown_cnt", n_up, 4);
    chk("rev_updown_lvl", updown, 1);
    clr();
    set_ab(fwd_seq[1]); run(10);
    set_ab(fwd_seq[2]); run(10);
    chk("refwd_pulses", n_en, 2);
    chk("refwd_updown_cnt", n_up, 0);
    run(10);
    chk("refwd_updown_hold", updown, 0);
    set_ab(fwd_seq[1]); run(10);
    set_ab(fwd_seq[0]); run(10);

    clr();
    a_in = 1'b1;
    run(2);
    a_in = 1'b0;
    run(10);
    chk("glitch_pulses", n_en, 0);
    chk("glitch_error", error, 0);

    first_e = -1; second_e = -1; first_ud = -1; second_ud = -1;
    a_in = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clock); #1;
      if (e == 3) a_in = 1'b0;
      if (enable) begin
        if (first_e < 0) begin first_e = e; first_ud = updown; end
        else if (second_e < 0) begin second_e = e; second_ud = updown; end
      end
    end
    chk("latency_fwd_edge", first_e, 5);
    chk("latency_fwd_ud", first_ud, 0);
    chk("latency_rev_edge", second_e, 9);
    chk("latency_rev_ud", second_ud, 1);

    clr();
    set_ab(2'b11);
    run(10);
    chk("illegal_pulses", n_en, 0);
    chk("illegal_error", error, 1);
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    chk("errclr_error", error, 0);
    clr();
    set_ab(2'b01);
    run(10);
    chk("post_err_pulses", n_en, 1);
    chk("post_err_updown", n_up, 0);

    set_ab(2'b11); run(10);
    set_ab(2'b00); run(10);
    set_ab(2'b11); run(10);
    chk("pre_rst_error", error, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_enable", enable, 0);
    chk("midrst_error", error, 0);
    clr();
    run(20);
    chk("midrst_pulses", n_en, 0);
    chk("midrst_error_settled", error, 0);
    clr();
    set_ab(2'b01);
    run(10);
    chk("midrst_step_pulses", n_en, 1);
    chk("midrst_step_updown", n_up, 0);

    clr();
    set_ab(2'b00);
    idx_in = 1'b1;
    run(10);
    chk("idx_load", n_ld, 1);
    chk("idx_enable", n_en, 1);
    chk("idx_both", n_both, 1);
    clr();
    idx_in = 1'b0;
    run(10);
    chk("idx_fall_load", n_ld, 0);
    chk("idx_fall_enable", n_en, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
